// File: rtl/dc1_xbit_fill_pkg.sv
// Shared types for the dc1 pbit line-fill sequencer and its fill FIFO.
package dc1_xbit_fill_pkg;
  localparam int PBIT_HALF_W = 16;
  localparam int LINE_PBIT_W = 2 * PBIT_HALF_W;
  localparam int ROW_MAX_W   = 16;

  // row is sized for the widest supported ADDR_WIDTH; the top zero-extends into it
  typedef struct packed {
    logic [ROW_MAX_W-1:0]   row;
    logic                   odd;
    logic [LINE_PBIT_W-1:0] pbits;
  } fill_entry_t;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} fill_state_e;

  function automatic logic byte_par_ok(input logic [LINE_PBIT_W-1:0] d, input logic [3:0] p);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) ok &= ^{d[8*i +: 8], p[i]};
    return ok;
  endfunction
endpackage

// File: rtl/dc1_xbit_fill_fifo.sv
// Synchronous FIFO of fill entries with registered full/empty flags.
module dc1_xbit_fill_fifo
  import dc1_xbit_fill_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  fill_entry_t            push_data,
  input  logic                   pop,
  output fill_entry_t            head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);

  fill_entry_t   mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   cnt_nxt;
  logic          do_push, do_pop;

  // a push into a full FIFO is legal when the head leaves in the same cycle
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_comb begin
    cnt_nxt = count;
    if (do_push & ~do_pop)      cnt_nxt = count + 1'b1;
    else if (~do_push & do_pop) cnt_nxt = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= cnt_nxt;
      full  <= (cnt_nxt == (PW+1)'(DEPTH));
      empty <= (cnt_nxt == '0);
    end
  end
endmodule

// File: rtl/dc1_xbit_fill.sv
// Line-fill sequencer and write-port-0 arbiter for the dc1 pbit store.
// Optional byte-parity check on fill data: define DC1_XBIT_FILL_PARITY_EN.
module dc1_xbit_fill
  import dc1_xbit_fill_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fill_valid,
  output logic                   fill_ready,
  input  logic [ADDR_WIDTH-1:0]  fill_row,
  input  logic                   fill_odd,
  input  logic [31:0]            fill_pbits,
  input  logic [3:0]             fill_par,
  input  logic                   st_clkEn,
  input  logic [ADDR_WIDTH+4:0]  st_addrE,
  input  logic [ADDR_WIDTH+4:0]  st_addrO,
  input  logic                   st_odd,
  input  logic                   st_d128,
  input  logic [1:0]             st_pbit,
  output logic                   st_stall,
  output logic                   write0_clkEn,
  output logic [ADDR_WIDTH+4:0]  write0_addrE,
  output logic [ADDR_WIDTH+4:0]  write0_addrO,
  output logic                   write0_odd,
  output logic                   write0_d128,
  output logic [1:0]             write0_pbit,
  output logic [1:0]             write_ins,
  output logic [PBIT_HALF_W-1:0] write_data,
  output logic                   fill_busy,
  output logic                   fill_perr
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fill_entry_t   push_data, head;
  fill_state_e   state;
  logic [SW-1:0] starve;
  logic [CW-1:0] count;
  logic          full, empty, push, pop, want, grant, beat, half;
  logic [ADDR_WIDTH+4:0] beat_addr;
  logic          unused_row;

  assign fill_ready = ~full;
  assign push       = fill_valid & ~full;
  assign unused_row = ^head.row;

  always_comb begin
    push_data     = '0;
    push_data.row = ROW_MAX_W'(fill_row);
    push_data.odd = fill_odd;
`ifdef DC1_XBIT_FILL_PARITY_EN
    push_data.pbits = byte_par_ok(fill_pbits, fill_par) ? fill_pbits : '0;
`else
    push_data.pbits = fill_pbits;
`endif
  end

`ifdef DC1_XBIT_FILL_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) fill_perr <= 1'b0;
    else     fill_perr <= push & ~byte_par_ok(fill_pbits, fill_par);
  end
`else
  logic unused_par;
  assign unused_par = ^fill_par;
  assign fill_perr  = 1'b0;
`endif

  dc1_xbit_fill_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // beats are issued combinationally from the state naming the pending half
  assign want  = ~rst & ((state != IDLE) | ~empty);
  assign grant = ~st_clkEn | full | (starve == SW'(STARVE_MAX));
  assign beat  = want & grant;
  assign half  = (state == BEAT1);
  assign pop   = beat & half;
  assign beat_addr = {half, head.row[ADDR_WIDTH-1:0], 4'b0000};
  assign fill_busy = ~empty | (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      starve <= '0;
    end else begin
      if (beat)
        starve <= '0;
      else if (st_clkEn & ~empty & (starve != SW'(STARVE_MAX)))
        starve <= starve + 1'b1;
      if (beat)
        state <= half ? (((count > CW'(1)) | push) ? BEAT0 : IDLE) : BEAT1;
    end
  end

  always_comb begin
    write0_clkEn = st_clkEn;
    write0_addrE = st_addrE;
    write0_addrO = st_addrO;
    write0_odd   = st_odd;
    write0_d128  = st_d128;
    write0_pbit  = st_pbit;
    write_ins    = 2'b00;
    write_data   = '0;
    st_stall     = 1'b0;
    if (rst) begin
      write0_clkEn = 1'b0;
      write0_addrE = '0;
      write0_addrO = '0;
      write0_odd   = 1'b0;
      write0_d128  = 1'b0;
      write0_pbit  = 2'b00;
    end else if (beat) begin
      write0_clkEn = 1'b0;
      write0_addrE = beat_addr;
      write0_addrO = beat_addr;
      write0_odd   = 1'b0;
      write0_d128  = 1'b0;
      write0_pbit  = 2'b00;
      write_ins    = head.odd ? 2'b10 : 2'b01;
      write_data   = half ? head.pbits[LINE_PBIT_W-1:PBIT_HALF_W] : head.pbits[PBIT_HALF_W-1:0];
      st_stall     = st_clkEn;
    end
  end
endmodule
